writeback_control: RTL and testbench
====================================

Name: writeback_control

Overview:
- Register-file write side of the pipeline; counterpart to decode's read-register selection.
- Holds the MEM/WB pipeline register and decodes the retiring instruction's opcode.
- Produces the register-file write port (enable, destination, data), including jal link, setx and overflow-exception writes to the status register.
- Feeds write-before-read bypass flags back to decode and counts retired instructions.

Parameters:
- RSTATUS, 30, register index written by setx and overflow exceptions
- RLINK, 31, register index written by jal

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  hold the stage register contents
- flush  in  1  load a bubble into the stage register
- in_valid  in  1  the incoming instruction is real
- in_instruction  in  32  instruction from MEM; opcode [31:27], rd [26:22], rs [21:17], rt [16:12], ALU op [6:2], target [26:0]
- in_alu_result  in  32  ALU result from MEM
- in_mem_data  in  32  load data from MEM
- in_pc_plus1  in  32  PC+1 of the incoming instruction
- in_overflow  in  1  ALU overflow flag for the incoming instruction
- read_reg_s1  in  5  decode's source register 1
- read_reg_s2  in  5  decode's source register 2
- ctrl_writeEnable  out  1  register-file write enable
- ctrl_writeReg  out  5  register-file write index
- data_writeReg  out  32  register-file write data
- bypass_s1  out  1  this cycle's write targets read_reg_s1
- bypass_s2  out  1  this cycle's write targets read_reg_s2
- retired_count  out  32  number of valid instructions retired

Behaviour:
- Stage register: valid_q, instr_q, alu_q, mem_q, pc1_q, ovf_q. All outputs are combinational from these registers; latency is one edge from the in_* inputs.
- Edge priority is reset > flush > stall > capture.
  - reset: all stage registers cleared to 0 and retired_count cleared to 0.
  - flush: valid_q is cleared; the other stage registers are don't-care.
  - stall without flush: all stage registers hold.
  - otherwise: all in_* inputs are captured.
- Reset values: ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0, bypass_s1=0, bypass_s2=0, retired_count=0.
- Write-class opcodes:
  - 00000 ALU
  - 00101 addi
  - 01000 lw
  - 00011 jal
  - 10101 setx
  - All others (sw, j, bne, blt, jr, bex, undefined) never write.
- Exception condition: ovf_q=1 AND one of the following:
  - opcode 00000 with ALU op 00000 (add), code 1
  - opcode 00101 (addi), code 2
  - opcode 00000 with ALU op 00001 (sub), code 3
  - ovf_q is ignored for every other instruction.
- ctrl_writeReg:
  - RLINK for jal
  - RSTATUS for setx or an exception
  - otherwise instr_q[26:22]
- data_writeReg:
  - exception: the exception code, zero-extended
  - lw: mem_q
  - jal: pc1_q
  - setx: {5'b0, instr_q[26:0]}
  - otherwise alu_q
- Writes to r0 are suppressed. ctrl_writeEnable = valid_q AND write-class AND (ctrl_writeReg != 0). Other outputs still show decoded values when the enable is low.
- bypass_sN = ctrl_writeEnable AND (ctrl_writeReg == read_reg_sN). read_reg_sN = 0 never asserts a bypass.
- Stall does not gate the write. The write repeats every stalled cycle; this is idempotent.
- retired_count increments by 1 on an edge where valid_q=1 and (stall=0 or flush=1), with reset=0.
  - It wraps from FFFFFFFF to 0.
  - Bubbles never count.
- Reset asserted mid-stall or mid-flush clears everything on that edge.

Test Plan:
- Reset, then `add r5,r1,r2` with alu=0x0000_0007, ovf=0, valid=1 -> next cycle: writeEnable=1, writeReg=5, data=7; read_reg_s2=5 gives bypass_s2=1; retired_count=1 after the following edge.
- `lw r9` with mem=0xDEAD_BEEF, alu=0x40 -> writeReg=9, data=0xDEADBEEF; `jal` with pc_plus1=0x0000_0123 -> writeReg=31, data=0x123; `setx 0x1234` -> writeReg=30, data=0x0000_1234.
- `addi r3` with ovf=1 -> writeReg=30, data=2; `sub` with ovf=1 -> data=3; `and` (ALU op 00010) with ovf=1 -> writeReg=rd, data=alu_q.
- `add r0,...`, `sw` and `bne` -> writeEnable=0, bypass_s1=bypass_s2=0 even with read_reg_s1=0; retired_count still increments for each.
- Valid add in stage, stall=1 for 3 cycles with new inputs applied -> outputs unchanged for 3 cycles, count unchanged; release -> new instruction appears and count increments once. stall=1 and flush=1 together -> bubble next cycle (writeEnable=0), held instruction counted once.
- Preload retired_count=0xFFFF_FFFF, retire one valid instruction -> count=0; reset asserted during a stall -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/writeback_control.sv
// Writeback stage: MEM/WB register, register-file write port,
// write-before-read bypass flags to decode and a retire counter.
module writeback_control #(
  parameter logic [4:0] RSTATUS = 5'd30,
  parameter logic [4:0] RLINK   = 5'd31
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        in_valid,
  input  logic [31:0] in_instruction,
  input  logic [31:0] in_alu_result,
  input  logic [31:0] in_mem_data,
  input  logic [31:0] in_pc_plus1,
  input  logic        in_overflow,
  input  logic [4:0]  read_reg_s1,
  input  logic [4:0]  read_reg_s2,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [31:0] data_writeReg,
  output logic        bypass_s1,
  output logic        bypass_s2,
  output logic [31:0] retired_count
);

  localparam logic [4:0] OP_ALU  = 5'b00000;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_JAL  = 5'b00011;
  localparam logic [4:0] OP_SETX = 5'b10101;
  localparam logic [4:0] AOP_ADD = 5'b00000;
  localparam logic [4:0] AOP_SUB = 5'b00001;

  logic        valid_q;
  logic [31:0] instr_q;
  logic [31:0] alu_q;
  logic [31:0] mem_q;
  logic [31:0] pc1_q;
  logic        ovf_q;
  logic [31:0] count_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      alu_q   <= '0;
      mem_q   <= '0;
      pc1_q   <= '0;
      ovf_q   <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (!stall) begin
      valid_q <= in_valid;
      instr_q <= in_instruction;
      alu_q   <= in_alu_result;
      mem_q   <= in_mem_data;
      pc1_q   <= in_pc_plus1;
      ovf_q   <= in_overflow;
    end
  end

  // An instruction retires when it leaves the stage, flushed or not.
  always_ff @(posedge clock) begin
    if (reset)
      count_q <= '0;
    else if (valid_q && (!stall || flush))
      count_q <= count_q + 32'd1;
  end

  logic [4:0]  op;
  logic [4:0]  aop;
  logic        wr_class;
  logic [1:0]  exc_code;
  logic [4:0]  wr_reg;
  logic [31:0] wr_data;

  assign op  = instr_q[31:27];
  assign aop = instr_q[6:2];

  always_comb begin
    wr_class = 1'b0;
    exc_code = 2'd0;
    wr_reg   = instr_q[26:22];
    wr_data  = alu_q;
    unique case (op)
      OP_ALU: begin
        wr_class = 1'b1;
        if (ovf_q && aop == AOP_ADD) exc_code = 2'd1;
        if (ovf_q && aop == AOP_SUB) exc_code = 2'd3;
      end
      OP_ADDI: begin
        wr_class = 1'b1;
        if (ovf_q) exc_code = 2'd2;
      end
      OP_LW: begin
        wr_class = 1'b1;
        wr_data  = mem_q;
      end
      OP_JAL: begin
        wr_class = 1'b1;
        wr_reg   = RLINK;
        wr_data  = pc1_q;
      end
      OP_SETX: begin
        wr_class = 1'b1;
        wr_reg   = RSTATUS;
        wr_data  = {5'b0, instr_q[26:0]};
      end
      default: wr_class = 1'b0;
    endcase
    if (exc_code != 2'd0) begin
      wr_reg  = RSTATUS;
      wr_data = {30'b0, exc_code};
    end
  end

  assign ctrl_writeReg    = wr_reg;
  assign data_writeReg    = wr_data;
  assign ctrl_writeEnable = valid_q && wr_class && (wr_reg != 5'd0);
  assign bypass_s1 = ctrl_writeEnable && (wr_reg == read_reg_s1);
  assign bypass_s2 = ctrl_writeEnable && (wr_reg == read_reg_s2);
  assign retired_count = count_q;

endmodule

// File: tb/tb_writeback_control.sv
// Self-checking bench for writeback_control: directed scenarios
// plus randomized traffic against a behavioural reference model.
module tb_writeback_control;

  logic        clock = 1'b0;
  logic        reset, stall, flush, in_valid, in_overflow;
  logic [31:0] in_instruction, in_alu_result, in_mem_data, in_pc_plus1;
  logic [4:0]  read_reg_s1, read_reg_s2;
  logic        ctrl_writeEnable, bypass_s1, bypass_s2;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg, retired_count;

  int checks = 0;
  int failures = 0;

  writeback_control dut (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_instruction(in_instruction),
    .in_alu_result(in_alu_result), .in_mem_data(in_mem_data),
    .in_pc_plus1(in_pc_plus1), .in_overflow(in_overflow),
    .read_reg_s1(read_reg_s1), .read_reg_s2(read_reg_s2),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
    .data_writeReg(data_writeReg), .bypass_s1(bypass_s1),
    .bypass_s2(bypass_s2), .retired_count(retired_count)
  );

  always #5 clock = ~clock;

  // Reference model: the instruction sitting in writeback and the count.
  logic        m_valid;
  logic [31:0] m_instr, m_alu, m_mem, m_pc1;
  logic        m_ovf;
  logic [31:0] m_cnt;

  function automatic logic [31:0] rtype(input logic [4:0] op, rd, rs, rt, aop);
    return {op, rd, rs, rt, 5'd0, aop, 2'b00};
  endfunction

  function automatic logic [71:0] observed();
    return {ctrl_writeEnable, ctrl_writeReg, data_writeReg,
            bypass_s1, bypass_s2, retired_count};
  endfunction

  function automatic logic [71:0] expected();
    logic [4:0] op, aop, wr;
    logic [31:0] code, wd;
    logic wc, we;
    op  = m_instr[31:27];
    aop = m_instr[6:2];
    wc  = op inside {5'b00000, 5'b00101, 5'b01000, 5'b00011, 5'b10101};
    code = 0;
    if (m_ovf && op == 5'b00000 && aop == 5'b00000) code = 1;
    if (m_ovf && op == 5'b00101) code = 2;
    if (m_ovf && op == 5'b00000 && aop == 5'b00001) code = 3;
    if (op == 5'b00011) wr = 5'd31;
    else if (op == 5'b10101 || code != 0) wr = 5'd30;
    else wr = m_instr[26:22];
    if (code != 0) wd = code;
    else if (op == 5'b01000) wd = m_mem;
    else if (op == 5'b00011) wd = m_pc1;
    else if (op == 5'b10101) wd = {5'b0, m_instr[26:0]};
    else wd = m_alu;
    we = m_valid && wc && wr != 5'd0;
    return {we, wr, wd, we && wr == read_reg_s1,
            we && wr == read_reg_s2, m_cnt};
  endfunction

  task automatic tick();
    @(posedge clock);
    if (reset) begin
      m_valid = 0; m_instr = 0; m_alu = 0; m_mem = 0;
      m_pc1 = 0; m_ovf = 0; m_cnt = 0;
    end else begin
      if (m_valid && (!stall || flush)) m_cnt = m_cnt + 1;
      if (flush) m_valid = 0;
      else if (!stall) begin
        m_valid = in_valid; m_instr = in_instruction;
        m_alu = in_alu_result; m_mem = in_mem_data;
        m_pc1 = in_pc_plus1; m_ovf = in_overflow;
      end
    end
    #1;
  endtask

  task automatic load(input logic [31:0] ins, alu, mem, pc1,
                      input logic ovf);
    stall = 0; flush = 0; reset = 0; in_valid = 1;
    in_instruction = ins; in_alu_result = alu;
    in_mem_data = mem; in_pc_plus1 = pc1; in_overflow = ovf;
    tick();
  endtask

  task automatic test_reset();
    reset = 1; stall = 0; flush = 0; in_valid = 1;
    in_instruction = rtype(5'd0, 5'd3, 5'd1, 5'd2, 5'd0);
    in_alu_result = 32'h1111; in_mem_data = 0; in_pc_plus1 = 0;
    in_overflow = 0; read_reg_s1 = 0; read_reg_s2 = 0;
    tick(); tick();
    checks++;
    if (observed() !== 72'd0) begin
      failures++;
      $display("FAIL reset_state got=%h want=0", observed());
    end
    reset = 0;
  endtask

  task automatic test_decode();
    read_reg_s1 = 5'd1; read_reg_s2 = 5'd5;
    load(rtype(5'd0, 5'd5, 5'd1, 5'd2, 5'd0), 32'h7, 0, 0, 0);
    checks++;
    if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg, bypass_s2, retired_count}
        !== {1'b1, 5'd5, 32'd7, 1'b1, 32'd0}) begin
      failures++;
      $display("FAIL add_r5 got=%h want we=1 reg=5 data=7 b2=1 cnt=0", observed());
    end
    load({5'b01000, 5'd9, 22'd0}, 32'h40, 32'hDEADBEEF, 0, 0);
    checks++;
    if ({ctrl_writeReg, data_writeReg, retired_count} !== {5'd9, 32'hDEADBEEF, 32'd1}) begin
      failures++;
      $display("FAIL lw_r9 got=%h want reg=9 data=deadbeef cnt=1", observed());
    end
    load({5'b00011, 27'd77}, 0, 0, 32'h123, 0);
    checks++;
    if ({ctrl_writeReg, data_writeReg} !== {5'd31, 32'h123}) begin
      failures++;
      $display("FAIL jal got reg=%0d data=%h want 31/123", ctrl_writeReg, data_writeReg);
    end
    load({5'b10101, 27'h1234}, 0, 0, 0, 0);
    checks++;
    if ({ctrl_writeReg, data_writeReg} !== {5'd30, 32'h1234}) begin
      failures++;
      $display("FAIL setx got reg=%0d data=%h want 30/1234", ctrl_writeReg, data_writeReg);
    end
    load({5'b00101, 5'd3, 5'd1, 17'd9}, 32'h55, 0, 0, 1);
    checks++;
    if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg} !== {1'b1, 5'd30, 32'd2}) begin
      failures++;
      $display("FAIL addi_ovf got reg=%0d data=%h want 30/2", ctrl_writeReg, data_writeReg);
    end
    load(rtype(5'd0, 5'd4, 5'd1, 5'd2, 5'd1), 32'h66, 0, 0, 1);
    checks++;
    if ({ctrl_writeReg, data_writeReg} !== {5'd30, 32'd3}) begin
      failures++;
      $display("FAIL sub_ovf got reg=%0d data=%h want 30/3", ctrl_writeReg, data_writeReg);
    end
    load(rtype(5'd0, 5'd6, 5'd1, 5'd2, 5'd2), 32'h77, 0, 0, 1);
    checks++;
    if ({ctrl_writeReg, data_writeReg} !== {5'd6, 32'h77}) begin
      failures++;
      $display("FAIL and_ovf got reg=%0d data=%h want 6/77", ctrl_writeReg, data_writeReg);
    end
    read_reg_s1 = 5'd0; read_reg_s2 = 5'd0;
    load(rtype(5'd0, 5'd0, 5'd1, 5'd2, 5'd0), 32'h9, 0, 0, 0);
    checks++;
    if ({ctrl_writeEnable, bypass_s1, bypass_s2, retired_count} !== {3'b000, 32'd7}) begin
      failures++;
      $display("FAIL add_r0 got=%h want we=0 b=0 cnt=7", observed());
    end
    load({5'b00111, 5'd8, 22'd0}, 32'h1, 0, 0, 0);
    read_reg_s1 = 5'd8; #1;
    checks++;
    if ({ctrl_writeEnable, bypass_s1, retired_count} !== {2'b00, 32'd8}) begin
      failures++;
      $display("FAIL sw got=%h want we=0 cnt=8", observed());
    end
    load({5'b00010, 5'd8, 22'd0}, 32'h1, 0, 0, 0);
    checks++;
    if ({ctrl_writeEnable, retired_count} !== {1'b0, 32'd9}) begin
      failures++;
      $display("FAIL bne got=%h want we=0 cnt=9", observed());
    end
    checks++;
    if (observed() !== expected()) begin
      failures++;
      $display("FAIL decode_model got=%h want=%h", observed(), expected());
    end
  endtask

  task automatic test_stall();
    logic [71:0] snap;
    read_reg_s1 = 5'd7; read_reg_s2 = 5'd2;
    load(rtype(5'd0, 5'd7, 5'd1, 5'd2, 5'd0), 32'hAB, 0, 0, 0);
    snap = observed();
    for (int i = 0; i < 3; i++) begin
      stall = 1;
      in_instruction = rtype(5'd0, 5'd12, 5'd1, 5'd2, 5'd0);
      in_alu_result = $urandom;
      tick();
      checks++;
      if (observed() !== snap) begin
        failures++;
        $display("FAIL stall_hold[%0d] got=%h want=%h", i, observed(), snap);
      end
    end
    load(rtype(5'd0, 5'd12, 5'd1, 5'd2, 5'd0), 32'hCD, 0, 0, 0);
    checks++;
    if ({ctrl_writeReg, data_writeReg, retired_count}
        !== {5'd12, 32'hCD, snap[31:0] + 32'd1}) begin
      failures++;
      $display("FAIL stall_release got=%h", observed());
    end
    snap = observed();
    stall = 1; flush = 1; tick();
    checks++;
    if ({ctrl_writeEnable, retired_count} !== {1'b0, snap[31:0] + 32'd1}) begin
      failures++;
      $display("FAIL stall_flush got=%h want we=0 cnt+1", observed());
    end
    stall = 0; flush = 0; tick();
    checks++;
    if (observed() !== expected()) begin
      failures++;
      $display("FAIL stall_model got=%h want=%h", observed(), expected());
    end
  endtask

  task automatic test_wrap();
    load(rtype(5'd0, 5'd4, 5'd1, 5'd2, 5'd0), 32'h5, 0, 0, 0);
    @(negedge clock);
    force dut.count_q = 32'hFFFF_FFFF;
    #1 release dut.count_q;
    m_cnt = 32'hFFFF_FFFF;
    load(rtype(5'd0, 5'd4, 5'd1, 5'd2, 5'd0), 32'h6, 0, 0, 0);
    checks++;
    if (retired_count !== 32'd0) begin
      failures++;
      $display("FAIL count_wrap got=%h want=0", retired_count);
    end
    stall = 1; tick();
    reset = 1; tick();
    reset = 0; stall = 0; in_valid = 0;
    checks++;
    if (observed() !== 72'd0) begin
      failures++;
      $display("FAIL reset_in_stall got=%h want=0", observed());
    end
  endtask

  task automatic test_random();
    logic [4:0] ops [8] = '{5'b00000, 5'b00101, 5'b01000, 5'b00011,
                            5'b10101, 5'b00111, 5'b00010, 5'b11111};
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      reset = ($urandom_range(0, 49) == 0);
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 9) == 0);
      in_valid = ($urandom_range(0, 4) != 0);
      in_instruction = $urandom;
      in_instruction[31:27] = ops[$urandom_range(0, 7)];
      in_instruction[26:22] = 5'($urandom_range(0, 3) == 0 ? 0 : $urandom);
      in_instruction[6:2] = 5'($urandom_range(0, 3));
      in_alu_result = $urandom; in_mem_data = $urandom;
      in_pc_plus1 = $urandom; in_overflow = $urandom_range(0, 1);
      read_reg_s1 = 5'($urandom_range(0, 3) == 0 ? 30 : $urandom);
      read_reg_s2 = 5'($urandom_range(0, 3) == 0 ? in_instruction[26:22] : $urandom);
      tick();
      checks++;
      if (observed() !== expected()) begin
        failures++;
        $display("FAIL random[%0d] got=%h want=%h", i, observed(), expected());
      end
    end
  endtask

  initial begin
    m_valid = 0; m_instr = 0; m_alu = 0; m_mem = 0;
    m_pc1 = 0; m_ovf = 0; m_cnt = 0;
    test_reset();
    test_decode();
    test_stall();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
